// File: rtl/plru_update_ctrl_if.sv
// Request/response handshake between the cache control FSM (master) and the
// PLRU update controller (slave).
interface plru_update_ctrl_if #(
   parameter int unsigned S_INDEX = 4
) ();
   logic               req_valid;
   logic               req_ready;
   logic [S_INDEX-1:0] req_set;
   logic               req_hit;
   logic [1:0]         req_way;
   logic [3:0]         req_vmask;
   logic               resp_valid;
   logic               resp_ready;
   logic [1:0]         resp_way;

   modport master (
      output req_valid, req_set, req_hit, req_way, req_vmask, resp_ready,
      input  req_ready, resp_valid, resp_way
   );

   modport slave (
      input  req_valid, req_set, req_hit, req_way, req_vmask, resp_ready,
      output req_ready, resp_valid, resp_way
   );
endinterface

// File: rtl/plru_update_ctrl.sv
// Two-stage tree-PLRU controller for a 4-way cache: reads the set state on
// array port 0, resolves hit/victim way, writes the updated state on port 1.
module plru_update_ctrl #(
   parameter int unsigned S_INDEX = 4
) (
   input  logic               clk0,
   input  logic               rst0_n,
   plru_update_ctrl_if.slave  bus,
   output logic               lru_csb0,
   output logic               lru_web0,
   output logic [S_INDEX-1:0] lru_addr0,
   input  logic [2:0]         lru_dout0,
   output logic               lru_csb1,
   output logic               lru_web1,
   output logic [S_INDEX-1:0] lru_addr1,
   output logic [2:0]         lru_din1
);

   logic               s2_valid;
   logic [S_INDEX-1:0] s2_set;
   logic               s2_hit;
   logic [1:0]         s2_way;
   logic [3:0]         s2_vmask;

   logic               accept;
   logic               fire;
   logic [1:0]         sel_way;
   logic [2:0]         new_bits;

   assign bus.req_ready  = !s2_valid || bus.resp_ready;
   assign accept         = bus.req_valid && bus.req_ready;
   assign fire           = s2_valid && bus.resp_ready;

   // Port 0 is only strobed on accept, so a stall keeps lru_dout0 stable.
   assign lru_csb0       = !accept;
   assign lru_web0       = 1'b1;
   assign lru_addr0      = bus.req_set;

   assign bus.resp_valid = s2_valid;
   assign bus.resp_way   = sel_way;

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         s2_valid <= 1'b0;
         s2_set   <= '0;
         s2_hit   <= 1'b0;
         s2_way   <= '0;
         s2_vmask <= '0;
      end else if (accept) begin
         s2_valid <= 1'b1;
         s2_set   <= bus.req_set;
         s2_hit   <= bus.req_hit;
         s2_way   <= bus.req_way;
         s2_vmask <= bus.req_vmask;
      end else if (fire) begin
         s2_valid <= 1'b0;
      end
   end

   always_comb begin
      sel_way = s2_way;
      if (!s2_hit) begin
         if (!s2_vmask[0])      sel_way = 2'd0;
         else if (!s2_vmask[1]) sel_way = 2'd1;
         else if (!s2_vmask[2]) sel_way = 2'd2;
         else if (!s2_vmask[3]) sel_way = 2'd3;
         else if (!lru_dout0[0]) sel_way = {1'b0, lru_dout0[1]};
         else                    sel_way = {1'b1, lru_dout0[2]};
      end
   end

   // Tree bits are flipped to point away from the accessed way.
   always_comb begin
      new_bits = lru_dout0;
      case (sel_way)
         2'd0: begin new_bits[0] = 1'b1; new_bits[1] = 1'b1; end
         2'd1: begin new_bits[0] = 1'b1; new_bits[1] = 1'b0; end
         2'd2: begin new_bits[0] = 1'b0; new_bits[2] = 1'b1; end
         default: begin new_bits[0] = 1'b0; new_bits[2] = 1'b0; end
      endcase
   end

   assign lru_csb1  = 1'b0;
   assign lru_web1  = !fire;
   assign lru_addr1 = fire ? s2_set : '0;
   assign lru_din1  = fire ? new_bits : '0;

endmodule

// File: tb/tb_plru_update_ctrl.sv
// Self-checking bench for plru_update_ctrl: behavioural LRU array plus a
// reference PLRU model, directed test-plan steps followed by random traffic.
module tb_plru_update_ctrl;

   logic       clk0 = 1'b0;
   logic       rst0_n = 1'b0;
   logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
   logic [3:0] lru_addr0, lru_addr1;
   logic [2:0] lru_dout0, lru_din1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk0 = ~clk0;

   plru_update_ctrl_if #(.S_INDEX(4)) bus ();

   plru_update_ctrl #(.S_INDEX(4)) dut (
      .clk0      (clk0),
      .rst0_n    (rst0_n),
      .bus       (bus),
      .lru_csb0  (lru_csb0),
      .lru_web0  (lru_web0),
      .lru_addr0 (lru_addr0),
      .lru_dout0 (lru_dout0),
      .lru_csb1  (lru_csb1),
      .lru_web1  (lru_web1),
      .lru_addr1 (lru_addr1),
      .lru_din1  (lru_din1)
   );

   // Dual-port array: registered inputs, write commits one edge later,
   // port-0 read transparent to the pending port-1 write.
   logic [2:0] mem [16];
   logic [3:0] raddr, paddr;
   logic       pw;
   logic [2:0] pdin;

   always @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 3'b000;
         raddr <= '0; paddr <= '0; pw <= 1'b0; pdin <= '0;
      end else begin
         if (pw) mem[paddr] <= pdin;
         if (!lru_csb0) raddr <= lru_addr0;
         if (!lru_csb1) begin
            pw <= !lru_web1; paddr <= lru_addr1; pdin <= lru_din1;
         end else begin
            pw <= 1'b0;
         end
      end
   end

   assign lru_dout0 = (pw && paddr == raddr) ? pdin : mem[raddr];

   // Reference model: per-set tree state and the single in-flight request.
   logic [2:0] ref_state [16];
   bit         m_v;
   int         m_set, m_way;
   bit         m_hit;
   logic [3:0] m_vm;

   function automatic int victim(input logic [2:0] s);
      int side = int'(s[0]);
      return side * 2 + (side == 1 ? int'(s[2]) : int'(s[1]));
   endfunction

   function automatic logic [2:0] touch(input logic [2:0] s, input int w);
      logic [2:0] r = s;
      r[0] = (w < 2);
      if (w < 2) r[1] = (w == 0);
      else       r[2] = (w == 2);
      return r;
   endfunction

   function automatic int pick(input bit hit, input int way, input logic [3:0] vm,
                               input logic [2:0] s);
      if (hit) return way;
      for (int i = 0; i < 4; i++) if (!vm[i]) return i;
      return victim(s);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit v, input int set, input bit hit, input int way,
                        input logic [3:0] vm, input bit rr,
                        input int want_way = -1, input int want_din = -1);
      bit exp_ready;
      int w;
      logic [2:0] nb;
      @(negedge clk0);
      bus.req_valid = v;
      bus.req_set   = 4'(set);
      bus.req_hit   = hit;
      bus.req_way   = 2'(way);
      bus.req_vmask = vm;
      bus.resp_ready = rr;
      #1;
      exp_ready = !m_v || rr;
      chk("req_ready", 8'(bus.req_ready), 8'(exp_ready));
      chk("lru_csb0", 8'(lru_csb0), 8'(!(v && exp_ready)));
      chk("lru_web0", 8'(lru_web0), 8'd1);
      chk("lru_csb1", 8'(lru_csb1), 8'd0);
      if (v && exp_ready) chk("lru_addr0", 8'(lru_addr0), 8'(set));
      chk("resp_valid", 8'(bus.resp_valid), 8'(m_v));
      if (want_way >= 0) begin
         chk("resp_valid_plan", 8'(bus.resp_valid), 8'd1);
         chk("resp_way_plan", 8'(bus.resp_way), 8'(want_way));
      end
      if (m_v) begin
         w  = pick(m_hit, m_way, m_vm, ref_state[m_set]);
         nb = touch(ref_state[m_set], w);
         chk("resp_way", 8'(bus.resp_way), 8'(w));
         if (rr) begin
            chk("lru_web1_fire", 8'(lru_web1), 8'd0);
            chk("lru_addr1", 8'(lru_addr1), 8'(m_set));
            chk("lru_din1", 8'(lru_din1), 8'(nb));
            if (want_din >= 0) chk("lru_din1_plan", 8'(lru_din1), 8'(want_din));
            ref_state[m_set] = nb;
            m_v = 1'b0;
         end else begin
            chk("lru_web1_stall", 8'(lru_web1), 8'd1);
         end
      end else begin
         chk("lru_web1_idle", 8'(lru_web1), 8'd1);
      end
      if (v && exp_ready) begin
         m_v = 1'b1; m_set = set; m_hit = hit; m_way = way; m_vm = vm;
      end
   endtask

   task automatic do_reset();
      @(negedge clk0);
      bus.req_valid = 1'b0; bus.req_set = '0; bus.req_hit = 1'b0;
      bus.req_way = '0; bus.req_vmask = 4'hF; bus.resp_ready = 1'b1;
      rst0_n = 1'b0;
      #1;
      chk("rst_resp_valid", 8'(bus.resp_valid), 8'd0);
      chk("rst_req_ready", 8'(bus.req_ready), 8'd1);
      chk("rst_lru_csb0", 8'(lru_csb0), 8'd1);
      chk("rst_lru_web0", 8'(lru_web0), 8'd1);
      chk("rst_lru_csb1", 8'(lru_csb1), 8'd0);
      chk("rst_lru_web1", 8'(lru_web1), 8'd1);
      chk("rst_lru_addr0", 8'(lru_addr0), 8'd0);
      chk("rst_lru_addr1", 8'(lru_addr1), 8'd0);
      chk("rst_lru_din1", 8'(lru_din1), 8'd0);
      @(negedge clk0);
      rst0_n = 1'b1;
      m_v = 1'b0;
      for (int i = 0; i < 16; i++) ref_state[i] = 3'b000;
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_set = '0; bus.req_hit = 1'b0;
      bus.req_way = '0; bus.req_vmask = 4'hF; bus.resp_ready = 1'b1;
      m_v = 1'b0;
      for (int i = 0; i < 16; i++) ref_state[i] = 3'b000;
      do_reset();

      // Single miss on set 5
      cycle(1, 5, 0, 0, 4'hF, 1);
      cycle(0, 0, 0, 0, 4'hF, 1, 0, 3'b011);

      // Back-to-back misses on set 5 from a clean state
      do_reset();
      cycle(1, 5, 0, 0, 4'hF, 1);
      cycle(1, 5, 0, 0, 4'hF, 1, 0, 3'b011);
      cycle(1, 5, 0, 0, 4'hF, 1, 2, 3'b110);
      cycle(1, 5, 0, 0, 4'hF, 1, 1, 3'b101);
      cycle(0, 0, 0, 0, 4'hF, 1, 3, 3'b000);

      // Hit then miss on set 3
      cycle(1, 3, 1, 2, 4'hF, 1);
      cycle(1, 3, 0, 0, 4'hF, 1, 2, 3'b100);
      cycle(0, 0, 0, 0, 4'hF, 1, 0, 3'b111);

      // Invalid way takes priority over PLRU on set 7
      cycle(1, 7, 0, 0, 4'b1011, 1);
      cycle(0, 0, 0, 0, 4'hF, 1, 2, 3'b100);

      // Five-cycle stall with a competing request held on the input
      cycle(1, 9, 0, 0, 4'hF, 1);
      for (int i = 0; i < 5; i++) cycle(1, 10, 0, 0, 4'hF, 0, 0);
      cycle(0, 0, 0, 0, 4'hF, 1, 0, 3'b011);

      // Reset while a write on set 5 is about to fire
      cycle(1, 5, 0, 0, 4'hF, 1);
      cycle(1, 5, 0, 0, 4'hF, 1, 0, 3'b011);
      do_reset();
      cycle(1, 5, 0, 0, 4'hF, 1);
      cycle(0, 0, 0, 0, 4'hF, 1, 0, 3'b011);

      // Random traffic concentrated on a few sets
      for (int n = 0; n < 400; n++) begin
         logic [3:0] vm;
         vm = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
               vm, $urandom_range(0, 3) != 0);
      end
      cycle(0, 0, 0, 0, 4'hF, 1);
      cycle(0, 0, 0, 0, 4'hF, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/plru_update_ctrl.md
# plru_update_ctrl

Pipelined tree-PLRU controller for a 4-way set-associative cache; it is the client side of the dual-port LRU state array. For each lookup it reads the set's 3-bit PLRU state on array port 0, returns the hit way or selects a replacement victim, and writes the updated state back on array port 1. It sits between the cache control FSM and the LRU array and sustains one request per cycle, including back-to-back requests to the same set.

## Interface
- S_INDEX, 4, set index width; the array holds 2**S_INDEX sets.
- clk0  in  1  clock; all state updates on the rising edge.
- rst0_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_set  in  S_INDEX  set index.
- req_hit  in  1  lookup hit.
- req_way  in  2  hitting way; meaningful only when req_hit=1.
- req_vmask  in  4  per-way valid bits of the set; used on a miss.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_way  out  2  hit way (hit), or chosen victim way (miss).
- lru_csb0, lru_web0  out  1 each  array port 0 chip select / write enable, both active-low.
- lru_addr0  out  S_INDEX  array port 0 address.
- lru_dout0  in  3  array port 0 read data; valid the cycle after the address is registered.
- lru_csb1, lru_web1  out  1 each  array port 1 chip select / write enable, both active-low.
- lru_addr1  out  S_INDEX  array port 1 address.
- lru_din1  out  3  array port 1 write data.

## Operation
- The clock is clk0 and the reset is rst0_n; reset is asynchronous and active-low.
- Array contract:
  - The array registers csb/web/addr/din at the edge where csb=0.
  - A write commits at the following edge.
  - Port 0 read data is transparent to a write pending on port 1.
  - Port 0 is read-only (lru_web0 = 1 always); the array's port-0 din is tied off at the top level.
- PLRU encoding, bits {b2,b1,b0}:
  - b0=0 selects the victim from ways 0/1; b0=1 selects from ways 2/3.
  - b1 chooses way0 (0) or way1 (1).
  - b2 chooses way2 (0) or way3 (1).
- Update on access to way w (the bits point away from w):
  - w0: b0=1, b1=1.
  - w1: b0=1, b1=0.
  - w2: b0=0, b2=1.
  - w3: b0=0, b2=0.
  - Untouched bits are kept.
- Stage 1 (accept):
  - req_ready = !s2_valid || resp_ready (combinational).
  - lru_csb0 = !(req_valid && req_ready); lru_addr0 = req_set.
  - On accept, register set, hit, way and vmask into S2 and set s2_valid.
- Stage 2 (resolve):
  - Hit: resp_way = s2_way.
  - Miss with any vmask bit 0: resp_way = lowest-index invalid way.
  - Otherwise: resp_way = PLRU victim from lru_dout0.
  - new_bits = update(lru_dout0, resp_way).
- Fire = resp_valid && resp_ready.
  - On fire: lru_csb1=0, lru_web1=0, lru_addr1=s2 set, lru_din1=new_bits.
  - When not firing: lru_csb1=0 and lru_web1=1, which clears any prior write.
  - Writes are issued only on fire, so a stalled response never writes.
- Stall (resp_valid && !resp_ready):
  - lru_csb0 stays 1, so the array's addr0 register and lru_dout0 hold.
  - S2 contents are held; resp_way stays stable.
- Same-set back-to-back: no internal forwarding. The write for request A is pending in the array port-1 register in the cycle B resolves, and port-0 transparency supplies A's new bits.

## Timing
- Reset values:
  - resp_valid=0, s2_valid=0, req_ready=1.
  - lru_csb0=1, lru_web0=1, lru_csb1=0, lru_web1=1.
  - lru_addr0, lru_addr1 and lru_din1 = 0.
- Latency: a request accepted at edge N has its response valid in cycle N+1 (combinational from lru_dout0). The write is registered at the fire edge and commits one edge later.
- Throughput: one request per cycle with resp_ready held high.
- Reset mid-operation: the S2 entry is dropped and no write is issued. The array is reset by the same system reset, so all sets return to 000.
- The PLRU state is exactly 3 bits; no width growth, and update() is total over all 8 input values.

## Test plan
- After reset, request set 5 miss, vmask=4'hF, array 000 -> resp_way=0 one cycle later; write set 5 = 3'b011.
- Back-to-back miss, vmask=F, set 5 x4, resp_ready=1 -> resp_way 0,2,1,3; final state 3'b000; one response per cycle.
- Hit set 3 way 2 (state 000), then miss set 3 -> resp_way=0 (state after the hit is 3'b100).
- Miss set 7, vmask=4'b1011 -> resp_way=2 (lowest invalid), state 3'b100, regardless of the PLRU bits.
- Hold resp_ready=0 for 5 cycles with S2 loaded -> req_ready=0, resp_way stable, lru_web1=1 throughout, lru_csb0=1; the single write occurs only on release.
- Assert rst0_n low while S2 is valid and a write is pending -> resp_valid=0 immediately (async), no write issued; the next miss on that set returns way 0.
